instr_reg_scheduler: RTL and testbench
======================================

Name: instr_reg_scheduler

Overview:
- Write/read sequencer and two-requester arbiter for the 32-entry instruction register.
- Accepts instructions from two independent requesters and arbitrates between them round-robin.
- Drives the register's load_en/write_pointer/opcode/operand_a/operand_b, then hands entries to one consumer in FIFO order via read_pointer.
- Tracks occupancy (count/full/empty); holds no instruction storage of its own.

Parameters:
DEPTH, 32, number of instruction register entries (power of 2)
ADDR_W, 5, pointer width, log2(DEPTH)
OPCODE_W, 4, opcode field width
OPERAND_W, 32, signed operand width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of pointers/count
req0_valid  in  1  requester 0 has an instruction
req0_ready  out  1  requester 0 accepted this cycle
req0_opcode  in  OPCODE_W  requester 0 opcode
req0_operand_a  in  OPERAND_W  requester 0 operand a
req0_operand_b  in  OPERAND_W  requester 0 operand b
req1_valid/req1_ready/req1_opcode/req1_operand_a/req1_operand_b  same as requester 0, for requester 1
rd_req  in  1  consumer requests next entry
rd_ack  out  1  read request accepted this cycle
load_en  out  1  write strobe to instruction register
write_pointer  out  ADDR_W  write address
opcode  out  OPCODE_W  write opcode
operand_a  out  OPERAND_W  write operand a
operand_b  out  OPERAND_W  write operand b
wr_src  out  1  requester whose data is on the write bus
read_pointer  out  ADDR_W  read address
rd_valid  out  1  instruction_word at read_pointer valid this cycle
count  out  ADDR_W+1  occupied entries, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer): wp, rp, count, load_en, write_pointer, read_pointer, opcode, operand_a, operand_b, wr_src, rd_valid = 0; rr_prio = 0. While reset is high, req0_ready, req1_ready and rd_ack are forced to 0. full=0, empty=1.
- Arbitration (combinational, same cycle): eligible only when !full && !flush.
  - Only one reqN_valid: grant N.
  - Both valid: grant rr_prio.
  - reqN_ready = grant N; at most one ready is high per cycle.
  - Each accept sets rr_prio <= ~N.
  - Priority does not change on idle cycles.
- Write issue (latency 1): accept in cycle T gives, in cycle T+1:
  - load_en=1, write_pointer=wp, opcode/operand_a/operand_b = granted payload, wr_src=N.
  - wp <= (wp+1) mod DEPTH, wrapping 31 -> 0.
  - With no accept, load_en=0 and the other write outputs hold their last values.
- Read: rd_ack = rd_req && !empty && !flush && !reset.
  - Ack in cycle T gives, in cycle T+1: read_pointer=rp, rd_valid=1; rp <= (rp+1) mod DEPTH.
  - No ack: rd_valid=0, read_pointer holds.
- Count:
  - +1 on write accept only; -1 on read ack only; unchanged when both occur in the same cycle.
  - full/empty are derived combinationally from registered count.
- Boundaries:
  - Full: both readies are 0, even if a read is acked in the same cycle (no bypass); space becomes available the next cycle.
  - Empty: rd_ack=0, even if a write is accepted in the same cycle.
  - Earliest read of a new entry is acked at T+1 with rd_valid at T+2. The register has captured the entry at the end of T+1, so no read-after-write hazard exists.
- Flush (synchronous): wp, rp and count <= 0; load_en and rd_valid <= 0 next cycle. Flush has priority over any accept or ack in the same cycle; rr_prio is unchanged.

Test Plan:
- Reset mid-write: accept from req0, assert reset in the following cycle -> load_en=0 and count=0 immediately; after release, first write goes to write_pointer=0.
- Contention: req0 and req1 valid for 4 cycles -> grants 0,1,0,1; wr_src sequence 0,1,0,1 at T+1; write_pointers 0,1,2,3; count=4.
- Fill/wrap: 32 writes from req1 -> full=1, count=32, req1_ready=0 on the 33rd. Then 32 reads -> read_pointer 0..31, empty=1. One more write -> write_pointer=0.
- Simultaneous: count=5, req0_valid and rd_req in the same cycle -> count stays 5; load_en and rd_valid both 1 next cycle.
- Full with read: count=32, req0_valid and rd_req -> rd_ack=1, req0_ready=0; next cycle req0_ready=1.
- Flush with pending req0_valid and rd_req at count=3 -> neither accepted; count=0, empty=1 next cycle; next write lands at write_pointer=0.

Source files
------------

// File: rtl/instr_reg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : instr_reg_scheduler
// Description : Round-robin arbiter between two instruction requesters and
//               write/read sequencer for a 32-entry instruction register.
//               Tracks occupancy only; the entries live in the register.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_reg_scheduler #(
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int OPCODE_W  = 4,
    parameter int OPERAND_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [OPCODE_W-1:0]  req0_opcode,
    input  logic [OPERAND_W-1:0] req0_operand_a,
    input  logic [OPERAND_W-1:0] req0_operand_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [OPCODE_W-1:0]  req1_opcode,
    input  logic [OPERAND_W-1:0] req1_operand_a,
    input  logic [OPERAND_W-1:0] req1_operand_b,
    input  logic                 rd_req,
    output logic                 rd_ack,
    output logic                 load_en,
    output logic [ADDR_W-1:0]    write_pointer,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [OPERAND_W-1:0] operand_a,
    output logic [OPERAND_W-1:0] operand_b,
    output logic                 wr_src,
    output logic [ADDR_W-1:0]    read_pointer,
    output logic                 rd_valid,
    output logic [ADDR_W:0]      count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [ADDR_W:0] C_FULL_COUNT = DEPTH[ADDR_W:0];

    // Internal pointers, occupancy and arbitration priority
    logic [ADDR_W-1:0]    wp_q, wp_d;
    logic [ADDR_W-1:0]    rp_q, rp_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 rr_prio_q, rr_prio_d;

    // Registered write/read bus outputs
    logic                 load_en_q, load_en_d;
    logic [ADDR_W-1:0]    write_pointer_q, write_pointer_d;
    logic [OPCODE_W-1:0]  opcode_q, opcode_d;
    logic [OPERAND_W-1:0] operand_a_q, operand_a_d;
    logic [OPERAND_W-1:0] operand_b_q, operand_b_d;
    logic                 wr_src_q, wr_src_d;
    logic [ADDR_W-1:0]    read_pointer_q, read_pointer_d;
    logic                 rd_valid_q, rd_valid_d;

    logic w_eligible;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_rd_ack;

    assign full  = (count_q == C_FULL_COUNT);
    assign empty = (count_q == '0);

    // Same-cycle arbitration and read acknowledge; reset and flush block all handshakes
    always_comb begin
        w_eligible = !full && !flush && !reset;
        w_grant0   = w_eligible && req0_valid && (!req1_valid || !rr_prio_q);
        w_grant1   = w_eligible && req1_valid && (!req0_valid ||  rr_prio_q);
        w_accept   = w_grant0 || w_grant1;
        w_rd_ack   = rd_req && !empty && !flush && !reset;
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rd_ack     = w_rd_ack;

    // Next-state: write issue, read issue, occupancy update; flush wins over both
    always_comb begin
        wp_d            = wp_q;
        rp_d            = rp_q;
        count_d         = count_q;
        rr_prio_d       = rr_prio_q;
        load_en_d       = 1'b0;
        write_pointer_d = write_pointer_q;
        opcode_d        = opcode_q;
        operand_a_d     = operand_a_q;
        operand_b_d     = operand_b_q;
        wr_src_d        = wr_src_q;
        read_pointer_d  = read_pointer_q;
        rd_valid_d      = 1'b0;

        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (w_accept) begin
                load_en_d       = 1'b1;
                write_pointer_d = wp_q;
                wr_src_d        = w_grant1;
                opcode_d        = w_grant1 ? req1_opcode    : req0_opcode;
                operand_a_d     = w_grant1 ? req1_operand_a : req0_operand_a;
                operand_b_d     = w_grant1 ? req1_operand_b : req0_operand_b;
                wp_d            = wp_q + ADDR_W'(1);
                rr_prio_d       = !w_grant1;
            end
            if (w_rd_ack) begin
                rd_valid_d     = 1'b1;
                read_pointer_d = rp_q;
                rp_d           = rp_q + ADDR_W'(1);
            end
            if (w_accept && !w_rd_ack) begin
                count_d = count_q + (ADDR_W+1)'(1);
            end else if (w_rd_ack && !w_accept) begin
                count_d = count_q - (ADDR_W+1)'(1);
            end
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q            <= '0;
            rp_q            <= '0;
            count_q         <= '0;
            rr_prio_q       <= 1'b0;
            load_en_q       <= 1'b0;
            write_pointer_q <= '0;
            opcode_q        <= '0;
            operand_a_q     <= '0;
            operand_b_q     <= '0;
            wr_src_q        <= 1'b0;
            read_pointer_q  <= '0;
            rd_valid_q      <= 1'b0;
        end else begin
            wp_q            <= wp_d;
            rp_q            <= rp_d;
            count_q         <= count_d;
            rr_prio_q       <= rr_prio_d;
            load_en_q       <= load_en_d;
            write_pointer_q <= write_pointer_d;
            opcode_q        <= opcode_d;
            operand_a_q     <= operand_a_d;
            operand_b_q     <= operand_b_d;
            wr_src_q        <= wr_src_d;
            read_pointer_q  <= read_pointer_d;
            rd_valid_q      <= rd_valid_d;
        end
    end

    assign load_en       = load_en_q;
    assign write_pointer = write_pointer_q;
    assign opcode        = opcode_q;
    assign operand_a     = operand_a_q;
    assign operand_b     = operand_b_q;
    assign wr_src        = wr_src_q;
    assign read_pointer  = read_pointer_q;
    assign rd_valid      = rd_valid_q;
    assign count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_reg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_reg_scheduler
// Description : Self-checking bench for instr_reg_scheduler. A queue-based
//               occupancy model predicts handshakes and bus outputs each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_reg_scheduler;

    localparam int DEPTH     = 32;
    localparam int ADDR_W    = 5;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 32;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 flush = 1'b0;
    logic                 req0_valid = 1'b0, req1_valid = 1'b0, rd_req = 1'b0;
    logic                 req0_ready, req1_ready, rd_ack;
    logic [OPCODE_W-1:0]  req0_opcode = '0, req1_opcode = '0;
    logic [OPERAND_W-1:0] req0_operand_a = '0, req0_operand_b = '0;
    logic [OPERAND_W-1:0] req1_operand_a = '0, req1_operand_b = '0;
    logic                 load_en, wr_src, rd_valid, full, empty;
    logic [ADDR_W-1:0]    write_pointer, read_pointer;
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand_a, operand_b;
    logic [ADDR_W:0]      count;

    instr_reg_scheduler #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
        .rd_req(rd_req), .rd_ack(rd_ack),
        .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .wr_src(wr_src),
        .read_pointer(read_pointer), .rd_valid(rd_valid),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queue of written addresses in FIFO order, next write address,
    // which requester wins a tie, and the registered outputs expected next cycle.
    int                   q[$];
    int                   wr_next = 0;
    int                   prio = 0;
    logic                 e_load_en = 0, e_wr_src = 0, e_rd_valid = 0;
    logic [ADDR_W-1:0]    e_wp = '0, e_rp = '0;
    logic [OPCODE_W-1:0]  e_opcode = '0;
    logic [OPERAND_W-1:0] e_a = '0, e_b = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wr_next = 0; prio = 0;
        e_load_en = 0; e_wr_src = 0; e_rd_valid = 0;
        e_wp = '0; e_rp = '0; e_opcode = '0; e_a = '0; e_b = '0;
    endtask

    // One cycle: drive inputs, compare every DUT output with the model, advance model
    task automatic step(input bit v0, input bit v1, input bit rq, input bit fl);
        bit g0, g1, ack, elig;
        @(negedge clk);
        req0_valid = v0; req1_valid = v1; rd_req = rq; flush = fl;
        req0_opcode = OPCODE_W'($urandom); req1_opcode = OPCODE_W'($urandom);
        req0_operand_a = $urandom; req0_operand_b = $urandom;
        req1_operand_a = $urandom; req1_operand_b = $urandom;
        #1;
        elig = (q.size() < DEPTH) && !fl;
        g0   = elig && v0 && (!v1 || prio == 0);
        g1   = elig && v1 && (!v0 || prio == 1);
        ack  = rq && (q.size() > 0) && !fl;
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("rd_ack", rd_ack, ack);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("load_en", load_en, e_load_en);
        chk("write_pointer", write_pointer, e_wp);
        chk("opcode", opcode, e_opcode);
        chk("operand_a", operand_a, e_a);
        chk("operand_b", operand_b, e_b);
        chk("wr_src", wr_src, e_wr_src);
        chk("read_pointer", read_pointer, e_rp);
        chk("rd_valid", rd_valid, e_rd_valid);
        if (fl) begin
            q.delete();
            wr_next = 0;
            e_load_en = 0; e_rd_valid = 0;
        end else begin
            e_rd_valid = ack;
            if (ack) e_rp = ADDR_W'(q.pop_front());
            e_load_en = g0 || g1;
            if (g0 || g1) begin
                e_wp     = ADDR_W'(wr_next);
                e_wr_src = g1;
                e_opcode = g1 ? req1_opcode    : req0_opcode;
                e_a      = g1 ? req1_operand_a : req0_operand_a;
                e_b      = g1 ? req1_operand_b : req0_operand_b;
                prio     = g1 ? 0 : 1;
                q.push_back(wr_next);
                wr_next  = (wr_next + 1) % DEPTH;
            end
        end
    endtask

    // Asynchronous reset asserted between edges; handshakes must drop while it is high
    task automatic do_reset();
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; rd_req = 1; flush = 0;
        reset = 1;
        #1;
        chk("rst load_en", load_en, 0);
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst req0_ready", req0_ready, 0);
        chk("rst req1_ready", req1_ready, 0);
        chk("rst rd_ack", rd_ack, 0);
        chk("rst write_pointer", write_pointer, 0);
        chk("rst read_pointer", read_pointer, 0);
        chk("rst rd_valid", rd_valid, 0);
        model_reset();
        @(negedge clk);
        reset = 0; req0_valid = 0; req1_valid = 0; rd_req = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();

        // Reset mid-write: load_en seen, then reset clears it immediately
        step(1, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("midwr load_en before reset", load_en, 1);
        chk("midwr count before reset", count, 1);
        do_reset();
        step(1, 0, 0, 0);
        @(posedge clk); #1;
        chk("after reset write_pointer", write_pointer, 0);

        // Contention: tie grants alternate 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            @(posedge clk); #1;
            chk("contention wr_src", wr_src, i % 2);
            chk("contention write_pointer", write_pointer, i);
        end
        chk("contention count", count, 4);

        // Fill from requester 1, then drain, then wrap
        do_reset();
        for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
        @(posedge clk); #1;
        chk("fill count", count, 32);
        chk("fill full", full, 1);
        step(0, 1, 0, 0);
        chk("fill 33rd req1_ready", req1_ready, 0);
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 1, 0);
            @(posedge clk); #1;
            chk("drain read_pointer", read_pointer, i);
        end
        chk("drain empty", empty, 1);
        step(1, 0, 0, 0);
        @(posedge clk); #1;
        chk("wrap write_pointer", write_pointer, 0);

        // Simultaneous write and read at count 5
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        @(posedge clk); #1;
        chk("simul count", count, 5);
        chk("simul load_en", load_en, 1);
        chk("simul rd_valid", rd_valid, 1);

        // Full with read: read acked, write refused, space next cycle
        do_reset();
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("fullrd rd_ack", rd_ack, 1);
        chk("fullrd req0_ready", req0_ready, 0);
        step(1, 0, 0, 0);
        chk("fullrd next req0_ready", req0_ready, 1);

        // Flush with pending write and read at count 3
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        chk("flush req0_ready", req0_ready, 0);
        chk("flush rd_ack", rd_ack, 0);
        @(posedge clk); #1;
        chk("flush count", count, 0);
        chk("flush empty", empty, 1);
        step(1, 0, 0, 0);
        @(posedge clk); #1;
        chk("flush write_pointer", write_pointer, 0);

        // Randomized traffic in write-heavy and read-heavy phases
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int wbias;
            wbias = ((i / 200) % 2 == 0) ? 80 : 25;
            step($urandom_range(99) < wbias, $urandom_range(99) < wbias,
                 $urandom_range(99) < (100 - wbias), $urandom_range(99) < 2);
            if ($urandom_range(999) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
